mailbox_mem_arbiter: RTL and testbench

- Shares the single Avalon-MM slave port of the on-chip Pi mailbox memory between two requesters.
- Port A is the SPI slave bridge (Pi host side). Port B is an FPGA-side client, e.g. the display controller fetching configuration or sprite data.
- Round-robin arbitration, one outstanding transaction at a time, fixed-latency reads.
- Sits between spi_slave and the SoPC mailbox s1 port, all on the 50 MHz clock domain.

---
 rtl/mailbox_arb_pkg.sv | 22 ++
 rtl/mailbox_arb_rr.sv | 23 ++
 rtl/mailbox_mem_arbiter.sv | 164 ++++++++++++++++
 tb/tb_mailbox_mem_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mailbox_arb_pkg.sv
// Shared types and limits for the Pi mailbox memory arbiter.
// The optional grant counters are enabled with MAILBOX_ARB_STATS_EN (see mailbox_mem_arbiter).
package mailbox_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RD_WAIT
  } arb_state_t;

  typedef enum logic {
    PORT_A,
    PORT_B
  } port_id_t;

  localparam int MAX_READ_LATENCY = 4;

  function automatic port_id_t other_port(input port_id_t p);
    return (p == PORT_A) ? PORT_B : PORT_A;
  endfunction

endpackage

// File: rtl/mailbox_arb_rr.sv
// Two-way round-robin pick: on a tie the port that did not win last time is chosen.
// Purely combinational; the last_grant register lives in the parent.
module mailbox_arb_rr
  import mailbox_arb_pkg::*;
(
  input  logic     req_a,
  input  logic     req_b,
  input  port_id_t last_grant,
  output logic     grant_valid,
  output port_id_t grant_id
);

  always_comb begin
    grant_valid = req_a | req_b;
    grant_id    = PORT_A;
    if (req_a && req_b) begin
      grant_id = other_port(last_grant);
    end else if (req_b) begin
      grant_id = PORT_B;
    end
  end

endmodule

// File: rtl/mailbox_mem_arbiter.sv
// Shares the mailbox s1 Avalon-MM slave between the SPI bridge (A) and an FPGA client (B).
// Define MAILBOX_ARB_STATS_EN to add saturating per-port grant counters.
module mailbox_mem_arbiter
  import mailbox_arb_pkg::*;
#(
  parameter int ADDR_W       = 28,
  parameter int DATA_W       = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic              iCLK,
  input  logic              iRST_n,

  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_ack,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,

  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_ack,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,

  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_read,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_writedata,
  input  logic [DATA_W-1:0] mem_readdata,
  input  logic              mem_waitrequest
`ifdef MAILBOX_ARB_STATS_EN
  ,
  output logic [15:0]       a_grant_cnt,
  output logic [15:0]       b_grant_cnt
`endif
);

  localparam int CNT_W     = $clog2(MAX_READ_LATENCY);
  // Out-of-range latencies are clamped so the counter can never wrap past its load value.
  localparam int LAT_CLAMP = (READ_LATENCY < 1) ? 1 :
                             (READ_LATENCY > MAX_READ_LATENCY) ? MAX_READ_LATENCY :
                             READ_LATENCY;
  localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(LAT_CLAMP - 1);

  arb_state_t        state_reg;
  port_id_t          grant_reg;
  port_id_t          last_grant_reg;
  logic [CNT_W-1:0]  lat_cnt_reg;

  logic              grant_valid;
  port_id_t          grant_id;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              accept;

  mailbox_arb_rr u_rr (
    .req_a       (a_req),
    .req_b       (b_req),
    .last_grant  (last_grant_reg),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  always_comb begin
    sel_we    = a_we;
    sel_addr  = a_addr;
    sel_wdata = a_wdata;
    if (grant_id == PORT_B) begin
      sel_we    = b_we;
      sel_addr  = b_addr;
      sel_wdata = b_wdata;
    end
  end

  // The command is taken by memory in the ISSUE cycle where waitrequest is low.
  assign accept = (state_reg == ISSUE) && !mem_waitrequest;
  assign a_ack  = accept && (grant_reg == PORT_A);
  assign b_ack  = accept && (grant_reg == PORT_B);

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state_reg      <= IDLE;
      grant_reg      <= PORT_A;
      last_grant_reg <= PORT_B;
      lat_cnt_reg    <= '0;
      mem_addr       <= '0;
      mem_read       <= 1'b0;
      mem_write      <= 1'b0;
      mem_writedata  <= '0;
      a_rvalid       <= 1'b0;
      b_rvalid       <= 1'b0;
      a_rdata        <= '0;
      b_rdata        <= '0;
    end else begin
      a_rvalid <= 1'b0;
      b_rvalid <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (grant_valid) begin
            grant_reg      <= grant_id;
            last_grant_reg <= grant_id;
            mem_addr       <= sel_addr;
            mem_writedata  <= sel_wdata;
            mem_write      <= sel_we;
            mem_read       <= !sel_we;
            state_reg      <= ISSUE;
          end
        end
        ISSUE: begin
          if (!mem_waitrequest) begin
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            if (mem_read) begin
              lat_cnt_reg <= LAT_LOAD;
              state_reg   <= RD_WAIT;
            end else begin
              state_reg <= IDLE;
            end
          end
        end
        RD_WAIT: begin
          // Count 0 marks the cycle in which mem_readdata is valid.
          if (lat_cnt_reg == '0) begin
            if (grant_reg == PORT_A) begin
              a_rdata  <= mem_readdata;
              a_rvalid <= 1'b1;
            end else begin
              b_rdata  <= mem_readdata;
              b_rvalid <= 1'b1;
            end
            state_reg <= IDLE;
          end else begin
            lat_cnt_reg <= lat_cnt_reg - CNT_W'(1);
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

`ifdef MAILBOX_ARB_STATS_EN
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      a_grant_cnt <= '0;
      b_grant_cnt <= '0;
    end else begin
      if (a_ack && (a_grant_cnt != 16'hFFFF)) begin
        a_grant_cnt <= a_grant_cnt + 16'd1;
      end
      if (b_ack && (b_grant_cnt != 16'hFFFF)) begin
        b_grant_cnt <= b_grant_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mailbox_mem_arbiter.sv
// Self-checking bench for mailbox_mem_arbiter: vector table, corner sequences and random traffic.
// Grant counters are checked when MAILBOX_ARB_STATS_EN is defined.
module tb_mailbox_mem_arbiter;

  localparam int AW = 28;
  localparam int DW = 32;
  localparam int RL = 1;

  logic          iCLK    = 1'b0;
  logic          iRST_n  = 1'b0;
  logic          a_req   = 1'b0;
  logic          a_we    = 1'b0;
  logic [AW-1:0] a_addr  = '0;
  logic [DW-1:0] a_wdata = '0;
  logic          b_req   = 1'b0;
  logic          b_we    = 1'b0;
  logic [AW-1:0] b_addr  = '0;
  logic [DW-1:0] b_wdata = '0;
  logic          a_ack, a_rvalid, b_ack, b_rvalid;
  logic [DW-1:0] a_rdata, b_rdata;
  logic [AW-1:0] mem_addr;
  logic          mem_read, mem_write, mem_waitrequest;
  logic [DW-1:0] mem_writedata, mem_readdata;
`ifdef MAILBOX_ARB_STATS_EN
  logic [15:0]   a_grant_cnt, b_grant_cnt;
`endif

  always #5 iCLK = ~iCLK;

  mailbox_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .READ_LATENCY(RL)) dut (
    .iCLK(iCLK), .iRST_n(iRST_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_ack(a_ack), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_ack(b_ack), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write),
    .mem_writedata(mem_writedata), .mem_readdata(mem_readdata),
    .mem_waitrequest(mem_waitrequest)
`ifdef MAILBOX_ARB_STATS_EN
    , .a_grant_cnt(a_grant_cnt), .b_grant_cnt(b_grant_cnt)
`endif
  );

  // Contents of a never-written memory word.
  function automatic logic [DW-1:0] dflt(input logic [AW-1:0] a);
    return {4'hA, a} ^ 32'h0F0F_1234;
  endfunction

  // Avalon slave model: programmable waitrequest, fixed read latency RL.
  int            wait_target = 0;
  int            wait_cnt    = 0;
  int            accepted    = 0;
  logic [DW-1:0] smem   [256];
  logic          svalid [256] = '{default: 1'b0};
  logic [DW-1:0] rd_pipe [RL];

  assign mem_waitrequest = (mem_read || mem_write) && (wait_cnt < wait_target);
  assign mem_readdata    = rd_pipe[RL-1];

  always @(posedge iCLK) begin
    if (!(mem_read || mem_write)) wait_cnt <= 0;
    else if (mem_waitrequest)     wait_cnt <= wait_cnt + 1;
    if (mem_write && !mem_waitrequest) begin
      smem[mem_addr[7:0]]   <= mem_writedata;
      svalid[mem_addr[7:0]] <= 1'b1;
      accepted              <= accepted + 1;
    end
    if (mem_read && !mem_waitrequest) begin
      rd_pipe[0] <= svalid[mem_addr[7:0]] ? smem[mem_addr[7:0]] : dflt(mem_addr);
      accepted   <= accepted + 1;
    end else begin
      rd_pipe[0] <= 32'hBAD0_BAD0;
    end
    for (int i = 1; i < RL; i++) rd_pipe[i] <= rd_pipe[i-1];
  end

  // Requester protocol: req must stay high until its ack.
  logic a_pend = 1'b0, b_pend = 1'b0;
  always @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      a_pend <= 1'b0;
      b_pend <= 1'b0;
    end else begin
      assert (!(a_pend && !a_req)) else $error("protocol: a_req dropped before a_ack");
      assert (!(b_pend && !b_req)) else $error("protocol: b_req dropped before b_ack");
      a_pend <= a_req && !a_ack;
      b_pend <= b_req && !b_ack;
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    @(posedge iCLK); #2;
    iRST_n = 1'b0;
    a_req  = 1'b0;
    b_req  = 1'b0;
    repeat (2) @(posedge iCLK);
    #2 iRST_n = 1'b1;
  endtask

  // One transaction on one port with the other port idle; checks latency, data and bus behaviour.
  task automatic run_txn(input string nm, input logic port, input logic we,
                         input logic [AW-1:0] addr, input logic [DW-1:0] wdata, input int waitc,
                         input int exp_ack, input int exp_rv, input logic [DW-1:0] exp_rd);
    int            acc0, ack_c, rv_c;
    logic          other_seen, unstable, my_ack, my_rv;
    logic [DW-1:0] rd;
    acc0 = accepted; ack_c = -1; rv_c = -1; rd = '0; other_seen = 1'b0; unstable = 1'b0;
    @(posedge iCLK); #1;
    wait_target = waitc;
    if (port == 1'b0) begin a_we = we; a_addr = addr; a_wdata = wdata; a_req = 1'b1; end
    else              begin b_we = we; b_addr = addr; b_wdata = wdata; b_req = 1'b1; end
    for (int c = 0; c < 60; c++) begin
      @(negedge iCLK);
      my_ack = port ? b_ack : a_ack;
      my_rv  = port ? b_rvalid : a_rvalid;
      other_seen = other_seen | (port ? (a_ack | a_rvalid) : (b_ack | b_rvalid));
      if (c >= 1 && ack_c < 0) begin
        if (mem_addr !== addr || mem_write !== we || mem_read !== !we ||
            (we && mem_writedata !== wdata)) unstable = 1'b1;
      end
      if (ack_c < 0 && my_ack) begin
        ack_c = c;
        @(posedge iCLK); #1;
        a_req = 1'b0;
        b_req = 1'b0;
        if (we) break;
      end else if (ack_c >= 0 && my_rv) begin
        rv_c = c;
        rd   = port ? b_rdata : a_rdata;
        break;
      end
    end
    a_req = 1'b0;
    b_req = 1'b0;
    chk({nm, "_ack_cycle"}, 64'(ack_c), 64'(exp_ack));
    chk({nm, "_mem_stable"}, {63'd0, unstable}, 64'd0);
    if (we) begin
      @(negedge iCLK);
      chk({nm, "_cmd_drop"}, {62'd0, mem_read, mem_write}, 64'd0);
    end else begin
      chk({nm, "_rvalid_cycle"}, 64'(rv_c), 64'(exp_rv));
      chk({nm, "_rdata"}, {32'd0, rd}, {32'd0, exp_rd});
      @(negedge iCLK);
      my_rv = port ? b_rvalid : a_rvalid;
      chk({nm, "_rvalid_pulse"}, {63'd0, my_rv}, 64'd0);
      chk({nm, "_rdata_hold"}, {32'd0, (port ? b_rdata : a_rdata)}, {32'd0, exp_rd});
    end
    chk({nm, "_other_quiet"}, {63'd0, other_seen}, 64'd0);
    chk({nm, "_one_accept"}, 64'(accepted - acc0), 64'd1);
  endtask

  typedef struct {
    logic          port;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            waitc;
    int            exp_ack;
    int            exp_rv;
    logic [DW-1:0] exp_rd;
  } vec_t;

  vec_t          vecs [7];
  logic [DW-1:0] ref_mem [logic [AW-1:0]];

  initial begin
    int            exp_a, exp_b, na, nb, la, lb, pick, last;
    int            order[$], exp_order[$];
    logic          both, ga, gb, port, we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata, erd;
    int            waitc;

    vecs[0] = '{1'b0, 1'b1, 28'h10,       32'hDEADBEEF, 0, 1, -1, 32'h0};
    vecs[1] = '{1'b1, 1'b0, 28'h10,       32'h0,        0, 1,  3, 32'hDEADBEEF};
    vecs[2] = '{1'b0, 1'b1, 28'h20,       32'h12345678, 5, 6, -1, 32'h0};
    vecs[3] = '{1'b0, 1'b0, 28'h20,       32'h0,        2, 3,  5, 32'h12345678};
    vecs[4] = '{1'b1, 1'b1, 28'h0FFFFFFF, 32'hFFFFFFFF, 0, 1, -1, 32'h0};
    vecs[5] = '{1'b0, 1'b0, 28'h0FFFFFFF, 32'h0,        1, 2,  4, 32'hFFFFFFFF};
    vecs[6] = '{1'b1, 1'b0, 28'h30,       32'h0,        0, 1,  3, 32'hAF0F1204};

    // Reset state
    repeat (2) @(negedge iCLK);
    chk("reset_ctrl", {58'd0, mem_read, mem_write, a_ack, b_ack, a_rvalid, b_rvalid}, 64'd0);
    chk("reset_mem_addr", {36'd0, mem_addr}, 64'd0);
    chk("reset_mem_wdata", {32'd0, mem_writedata}, 64'd0);
    chk("reset_rdata", {a_rdata, b_rdata}, 64'd0);
    @(posedge iCLK); #2 iRST_n = 1'b1;

    exp_a = 0; exp_b = 0;
    for (int i = 0; i < 7; i++) begin
      run_txn($sformatf("vec%0d", i), vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata,
              vecs[i].waitc, vecs[i].exp_ack, vecs[i].exp_rv, vecs[i].exp_rd);
      if (vecs[i].we) ref_mem[vecs[i].addr] = vecs[i].wdata;
      if (vecs[i].port) exp_b++; else exp_a++;
    end
`ifdef MAILBOX_ARB_STATS_EN
    chk("stats_a_table", {48'd0, a_grant_cnt}, 64'(exp_a));
    chk("stats_b_table", {48'd0, b_grant_cnt}, 64'(exp_b));
`endif

    // Reset while a read is waiting for data
    @(posedge iCLK); #1;
    wait_target = 0;
    a_we = 1'b0; a_addr = 28'h10; a_req = 1'b1;
    @(negedge iCLK);
    @(negedge iCLK);
    chk("rstmid_ack", {63'd0, a_ack}, 64'd1);
    @(posedge iCLK); #1;
    a_req = 1'b0;
    #2 iRST_n = 1'b0;
    #1;
    chk("rstmid_cmd_low", {61'd0, mem_read, mem_write, a_rvalid}, 64'd0);
    chk("rstmid_rdata_clr", {32'd0, a_rdata}, 64'd0);
    both = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge iCLK);
      both = both | a_rvalid | b_rvalid | a_ack | b_ack;
    end
    chk("rstmid_no_pulse", {63'd0, both}, 64'd0);
    @(posedge iCLK); #2 iRST_n = 1'b1;
    run_txn("rstmid_next", 1'b0, 1'b0, 28'h10, 32'h0, 0, 1, 2 + RL, ref_mem[28'h10]);

    // Both ports requesting continuously after reset
    do_reset();
    @(posedge iCLK); #1;
    wait_target = 0;
    a_we = 1'b1; b_we = 1'b1;
    a_addr = 28'h40; b_addr = 28'h50;
    a_wdata = 32'hA000_0000; b_wdata = 32'hB000_0000;
    a_req = 1'b1; b_req = 1'b1;
    na = 0; nb = 0; both = 1'b0;
    for (int c = 0; c < 100 && (na + nb) < 6; c++) begin
      @(negedge iCLK);
      ga = a_ack; gb = b_ack;
      if (ga && gb) both = 1'b1;
      if (ga) begin order.push_back(0); ref_mem[a_addr] = a_wdata; na++; end
      if (gb) begin order.push_back(1); ref_mem[b_addr] = b_wdata; nb++; end
      @(posedge iCLK); #1;
      if (ga) begin
        if (na == 3) a_req = 1'b0;
        else begin a_addr = a_addr + 28'd1; a_wdata = a_wdata + 32'd1; end
      end
      if (gb) begin
        if (nb == 3) b_req = 1'b0;
        else begin b_addr = b_addr + 28'd1; b_wdata = b_wdata + 32'd1; end
      end
    end
    a_req = 1'b0; b_req = 1'b0;
    la = 3; lb = 3; last = 1;
    while (la + lb > 0) begin
      if (la > 0 && lb > 0) pick = 1 - last;
      else pick = (la > 0) ? 0 : 1;
      exp_order.push_back(pick);
      if (pick == 0) la--; else lb--;
      last = pick;
    end
    chk("rr_both_acked", {63'd0, both}, 64'd0);
    chk("rr_count", 64'(order.size()), 64'd6);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("rr_grant%0d", i), 64'((i < order.size()) ? order[i] : -1), 64'(exp_order[i]));
    end
`ifdef MAILBOX_ARB_STATS_EN
    chk("stats_a_rr", {48'd0, a_grant_cnt}, 64'd3);
    chk("stats_b_rr", {48'd0, b_grant_cnt}, 64'd3);
`endif
    run_txn("rr_readback", 1'b1, 1'b0, 28'h41, 32'h0, 0, 1, 2 + RL, ref_mem[28'h41]);

    // Random single-port traffic against the memory model
    for (int i = 0; i < 30; i++) begin
      port  = 1'($urandom_range(0, 1));
      we    = 1'($urandom_range(0, 1));
      addr  = 28'($urandom_range(0, 63));
      wdata = $urandom;
      waitc = int'($urandom_range(0, 3));
      erd   = ref_mem.exists(addr) ? ref_mem[addr] : dflt(addr);
      run_txn($sformatf("rnd%0d", i), port, we, addr, wdata, waitc,
              1 + waitc, we ? -1 : 2 + waitc + RL, we ? 32'h0 : erd);
      if (we) ref_mem[addr] = wdata;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
